imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory boot loader: receives a length-prefixed, checksummed byte
// stream and writes big-endian 32-bit words into instruction memory.
module imem_loader #(
   parameter int unsigned DEPTH = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        wr_en,
   output logic [9:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic        cpu_hold,
   output logic        done,
   output logic        err
);

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 8;
   localparam int unsigned LW = 16;
   localparam logic [LW-1:0] DEPTH_W = LW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERR
   } state_e;

   state_e          state_q, state_d;
   logic [LW-1:0]   len_q, len_d;
   logic [LW-1:0]   word_cnt_q, word_cnt_d;
   logic [1:0]      byte_cnt_q, byte_cnt_d;
   logic [23:0]     shift_q, shift_d;
   logic [BW-1:0]   csum_q, csum_d;
   logic            in_ready_q, in_ready_d;
   logic            wr_en_q, wr_en_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [DW-1:0]   wr_data_q, wr_data_d;
   logic            cpu_hold_q, cpu_hold_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic            accept;
   logic [LW-1:0]   len_full;

   assign accept   = in_valid & in_ready_q;
   assign len_full = {len_q[7:0], in_data};

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      csum_d     = csum_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d    = S_LEN_HI;
               len_d      = '0;
               word_cnt_d = '0;
               byte_cnt_d = '0;
               shift_d    = '0;
               csum_d     = '0;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               len_d   = {8'h00, in_data};
               state_d = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               len_d   = len_full;
               state_d = ((len_full == '0) || (len_full > DEPTH_W)) ? S_ERR : S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               csum_d = csum_q ^ in_data;
               if (byte_cnt_q == 2'd3) begin
                  wr_en_d    = 1'b1;
                  wr_addr_d  = AW'(word_cnt_q);
                  wr_data_d  = {shift_q, in_data};
                  byte_cnt_d = '0;
                  word_cnt_d = word_cnt_q + LW'(1);
                  if (word_cnt_q == (len_q - LW'(1))) begin
                     state_d = S_CHECK;
                  end
               end else begin
                  shift_d    = {shift_q[15:0], in_data};
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end
         S_CHECK: begin
            if (accept) begin
               state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Status flags track the state being entered so they change with it
      in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                   (state_d == S_DATA)   || (state_d == S_CHECK);
      done_d     = (state_d == S_DONE);
      err_d      = (state_d == S_ERR);
      cpu_hold_d = (state_d != S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         word_cnt_q <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         csum_q     <= '0;
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         csum_q     <= csum_d;
         in_ready_q <= in_ready_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign in_ready = in_ready_q;
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign cpu_hold = cpu_hold_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule
